// File: rtl/gyro_link_pkg.sv
// gyro_link_pkg
// Shared definitions for the gyro link responder slice:
//   WD_DEFAULT   default serial word width
//   link_state_t framing state (HUNT until the first frame marker, then ACTIVE)
//   ERR_SAT      saturation value of the error counter
//   satInc       saturating 16-bit increment used by the error counter
package gyro_link_pkg;

  localparam int WD_DEFAULT = 48;

  typedef enum logic {
    HUNT   = 1'b0,
    ACTIVE = 1'b1
  } link_state_t;

  localparam logic [15:0] ERR_SAT = 16'hFFFF;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == ERR_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gen_sync_que_af.sv
// gen_sync_que_af
// Single-clock first-word-fall-through FIFO of 2**DPWR entries of WD bits.
// Ports:
//   clk, rstn      clock, synchronous active-low reset (empties the queue)
//   push_i/data_i  write request and data; ignored while full
//   pop_i          read request; ignored while empty
//   data_o         current head entry (valid while empty_o is low)
//   full_o/empty_o occupancy flags
module gen_sync_que_af #(
  parameter int DPWR = 2,
  parameter int WD   = 48
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [WD-1:0] data_i,
  input  logic          pop_i,
  output logic [WD-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << DPWR;

  logic [WD-1:0] mem_q [DEPTH];
  logic [DPWR:0] wrPtr_q;
  logic [DPWR:0] rdPtr_q;
  logic          doPush;
  logic          doPop;

  assign doPush = push_i & ~full_o;
  assign doPop  = pop_i & ~empty_o;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[DPWR-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rdPtr_q[DPWR-1:0]];
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[DPWR] != rdPtr_q[DPWR]) &&
                   (wrPtr_q[DPWR-1:0] == rdPtr_q[DPWR-1:0]);

endmodule

// File: rtl/gyro_link_edge_sync.sv
// gyro_link_edge_sync
// Brings the asynchronous host pins into the clk domain and turns the bit
// clock into single-cycle rise/fall strobes.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   mck_pol_i            1 = host bit clock idles high, so it is inverted here
//   mck_i/dsync_i/dtx_i  raw host pins
//   rise_o/fall_o        one-clk strobes on bit clock edges (after polarity fix)
//   dsync_o/dtx_o        synchronized frame marker and data
module gyro_link_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic mck_pol_i,
  input  logic mck_i,
  input  logic dsync_i,
  input  logic dtx_i,
  output logic rise_o,
  output logic fall_o,
  output logic dsync_o,
  output logic dtx_o
);

  logic [SYNC_STAGES-1:0] mckSync_q;
  logic [SYNC_STAGES-1:0] dsyncSync_q;
  logic [SYNC_STAGES-1:0] dtxSync_q;
  logic                   mckDly_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   mckLevel;
  logic                   mckSynced;

  assign mckLevel  = mck_i ^ mck_pol_i;
  assign mckSynced = mckSync_q[SYNC_STAGES-1];

  // All three pins see the same synchronizer depth so data and frame marker
  // stay aligned with the bit clock strobes. The strobes are registered,
  // landing SYNC_STAGES+1 clocks after the pin edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mckSync_q   <= '0;
      dsyncSync_q <= '0;
      dtxSync_q   <= '0;
      mckDly_q    <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      mckSync_q[0]   <= mckLevel;
      dsyncSync_q[0] <= dsync_i;
      dtxSync_q[0]   <= dtx_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mckSync_q[i]   <= mckSync_q[i-1];
        dsyncSync_q[i] <= dsyncSync_q[i-1];
        dtxSync_q[i]   <= dtxSync_q[i-1];
      end
      mckDly_q <= mckSynced;
      rise_q   <= mckSynced & ~mckDly_q;
      fall_q   <= ~mckSynced & mckDly_q;
    end
  end

  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign dsync_o = dsyncSync_q[SYNC_STAGES-1];
  assign dtx_o   = dtxSync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gyro_link_responder.sv
// gyro_link_responder
// Device side of a framed serial link. The host supplies bit clock MCK,
// frame marker DSYNC (high on the last bit of each word) and data DTX.
// Received words go out on an AXI-stream style port through a FIFO; response
// words taken from a TX FIFO are shifted out MSB first on DRX.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   enable                       block enable (low forces HUNT, freezes counters)
//   mck_pol                      bit clock idle polarity
//   MCK, DSYNC, DTX              asynchronous host pins
//   DRX                          registered device-to-host data
//   rx_tdata/rx_tvalid/rx_tready received word stream
//   tx_tdata/tx_tvalid/tx_tready response word stream
//   frame_err/rx_overflow/tx_underrun  one-clk event pulses
//   word_cnt                     wrapping count of stored words
//   err_cnt                      saturating count of clocks with an error event
module gyro_link_responder
  import gyro_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DPWR        = 2,
  parameter int WD          = WD_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          mck_pol,
  input  logic          MCK,
  input  logic          DSYNC,
  input  logic          DTX,
  output logic          DRX,
  output logic [WD-1:0] rx_tdata,
  output logic          rx_tvalid,
  input  logic          rx_tready,
  input  logic [WD-1:0] tx_tdata,
  input  logic          tx_tvalid,
  output logic          tx_tready,
  output logic          frame_err,
  output logic          rx_overflow,
  output logic          tx_underrun,
  output logic [15:0]   word_cnt,
  output logic [15:0]   err_cnt
);

  localparam int             BCW      = $clog2(WD);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WD - 1);

  logic riseP;
  logic fallP;
  logic dsyncS;
  logic dtxS;

  link_state_t    state_q, state_d;
  logic [BCW-1:0] bitCnt_q, bitCnt_d;
  logic [WD-1:0]  rxShift_q, rxShift_d;
  logic [WD-1:0]  txShift_q, txShift_d;
  logic           pushPend_q, pushPend_d;
  logic           firstFall_q, firstFall_d;
  logic           drx_q, drx_d;
  logic           frameErr_q, frameErr_d;
  logic           overflow_q, overflow_d;
  logic           underrun_q, underrun_d;
  logic [15:0]    wordCnt_q, wordCnt_d;
  logic [15:0]    errCnt_q, errCnt_d;

  logic           rxPush;
  logic           rxFull;
  logic           rxEmpty;
  logic           txPush;
  logic           txPop;
  logic           txFull;
  logic           txEmpty;
  logic [WD-1:0]  txHead;

  gyro_link_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk      (clk),
    .rstn     (rstn),
    .mck_pol_i(mck_pol),
    .mck_i    (MCK),
    .dsync_i  (DSYNC),
    .dtx_i    (DTX),
    .rise_o   (riseP),
    .fall_o   (fallP),
    .dsync_o  (dsyncS),
    .dtx_o    (dtxS)
  );

  // Framing and transmit shifter. A DSYNC rise always closes the current
  // word: it is accepted only when exactly WD bits have been shifted, and
  // it arms firstFall so the following fall loads the next response word.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    rxShift_d   = rxShift_q;
    pushPend_d  = 1'b0;
    firstFall_d = firstFall_q;
    txShift_d   = txShift_q;
    drx_d       = drx_q;
    frameErr_d  = 1'b0;
    underrun_d  = 1'b0;
    txPop       = 1'b0;

    if (!enable) begin
      state_d     = HUNT;
      bitCnt_d    = '0;
      firstFall_d = 1'b0;
      drx_d       = 1'b0;
    end else begin
      if (riseP) begin
        if (state_q == HUNT) begin
          bitCnt_d = '0;
          if (dsyncS) begin
            state_d     = ACTIVE;
            firstFall_d = 1'b1;
          end
        end else begin
          rxShift_d = {rxShift_q[WD-2:0], dtxS};
          if (dsyncS) begin
            bitCnt_d    = '0;
            firstFall_d = 1'b1;
            if (bitCnt_q == LAST_BIT) begin
              pushPend_d = 1'b1;
            end else begin
              frameErr_d = 1'b1;
            end
          end else if (bitCnt_q == LAST_BIT) begin
            frameErr_d = 1'b1;
            bitCnt_d   = '0;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end

      if (fallP && (state_q == ACTIVE)) begin
        if (firstFall_q) begin
          firstFall_d = 1'b0;
          if (!txEmpty) begin
            txPop     = 1'b1;
            txShift_d = txHead;
          end else begin
            txShift_d  = '0;
            underrun_d = 1'b1;
          end
        end else begin
          txShift_d = {txShift_q[WD-2:0], 1'b0};
        end
        drx_d = txShift_d[WD-1];
      end
    end
  end

  // The completed word sits in rxShift_q for the clock after the closing
  // rise; the push (or overflow) is resolved then against the FIFO state.
  assign rxPush     = pushPend_q & enable & ~rxFull;
  assign overflow_d = pushPend_q & enable & rxFull;

  // Coincident events count once.
  always_comb begin
    wordCnt_d = wordCnt_q;
    errCnt_d  = errCnt_q;
    if (rxPush) wordCnt_d = wordCnt_q + 16'd1;
    if (frameErr_d | overflow_d | underrun_d) errCnt_d = satInc(errCnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= HUNT;
      bitCnt_q    <= '0;
      rxShift_q   <= '0;
      txShift_q   <= '0;
      pushPend_q  <= 1'b0;
      firstFall_q <= 1'b0;
      drx_q       <= 1'b0;
      frameErr_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
      wordCnt_q   <= '0;
      errCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      rxShift_q   <= rxShift_d;
      txShift_q   <= txShift_d;
      pushPend_q  <= pushPend_d;
      firstFall_q <= firstFall_d;
      drx_q       <= drx_d;
      frameErr_q  <= frameErr_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
      wordCnt_q   <= wordCnt_d;
      errCnt_q    <= errCnt_d;
    end
  end

  gen_sync_que_af #(
    .DPWR(DPWR),
    .WD  (WD)
  ) u_rx_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (rxPush),
    .data_i (rxShift_q),
    .pop_i  (rx_tready),
    .data_o (rx_tdata),
    .full_o (rxFull),
    .empty_o(rxEmpty)
  );

  assign tx_tready = ~txFull & enable;
  assign txPush    = tx_tvalid & tx_tready;

  gen_sync_que_af #(
    .DPWR(DPWR),
    .WD  (WD)
  ) u_tx_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (txPush),
    .data_i (tx_tdata),
    .pop_i  (txPop),
    .data_o (txHead),
    .full_o (txFull),
    .empty_o(txEmpty)
  );

  assign rx_tvalid   = ~rxEmpty;
  assign DRX         = drx_q;
  assign frame_err   = frameErr_q;
  assign rx_overflow = overflow_q;
  assign tx_underrun = underrun_q;
  assign word_cnt    = wordCnt_q;
  assign err_cnt     = errCnt_q;

endmodule

// File: doc/gyro_link_responder.md
GYRO_LINK_RESPONDER -- requirements
Module: gyro_link_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth applied to the MCK, DSYNC and DTX inputs.
REQ-002 Parameter DPWR, default 2: log2 depth of each word FIFO.
REQ-003 Parameter WD, default 48: serial word width in bits.
REQ-004 clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 enable  input  1  block enable.
REQ-007 mck_pol  input  1  MCK polarity; 0 = MCK rests low, 1 = MCK rests high and is inverted internally.
REQ-008 MCK  input  1  host master bit clock, asynchronous.
REQ-009 DSYNC  input  1  host frame marker, asynchronous.
REQ-010 DTX  input  1  host-to-device serial data, asynchronous.
REQ-011 DRX  output  1  device-to-host serial data.
REQ-012 rx_tdata  output  WD  received word.
REQ-013 rx_tvalid  output  1  rx_tdata is valid.
REQ-014 rx_tready  input  1  downstream accepts the received word.
REQ-015 tx_tdata  input  WD  response word.
REQ-016 tx_tvalid  input  1  tx_tdata is valid.
REQ-017 tx_tready  output  1  block accepts the response word.
REQ-018 frame_err  output  1  one-clk pulse on a framing error.
REQ-019 rx_overflow  output  1  one-clk pulse when a received word is dropped because the RX FIFO is full.
REQ-020 tx_underrun  output  1  one-clk pulse when a frame starts with the TX FIFO empty.
REQ-021 word_cnt  output  16  count of received words, wrapping.
REQ-022 err_cnt  output  16  count of frame_err, rx_overflow and tx_underrun events, saturating at 16'hFFFF.

Function
REQ-023 MCK (after the mck_pol XOR), DSYNC and DTX shall each pass through SYNC_STAGES flops.
REQ-024 The synchronized MCK shall feed one additional flop used for edge detection.
REQ-025 A rise pulse shall assert for one clk on a synchronized 0->1 MCK transition.
REQ-026 A fall pulse shall assert for one clk on a synchronized 1->0 MCK transition.
REQ-027 Rise and fall pulses shall occur SYNC_STAGES+1 clk after the pin edge.
REQ-028 The MCK high time and the MCK low time shall each be at least 4 clk periods; the bench shall not drive faster MCK.
REQ-029 On each rise pulse: shift synchronized DTX into rx_shift, MSB first; increment bit_cnt (0..WD-1).
REQ-030 Rise pulse with DSYNC=1 and bit_cnt==WD-1: word complete; FIFO push on the next clk; rx_tvalid high 1 clk after the push.
REQ-031 Rise pulse with DSYNC=1 and bit_cnt!=WD-1: pulse frame_err; discard the word.
REQ-032 Rise pulse with DSYNC=0 and bit_cnt==WD-1: pulse frame_err; discard the word.
REQ-033 bit_cnt shall return to 0 after every DSYNC=1 sample and after every frame error.
REQ-034 Word complete with the RX FIFO full: drop the word; pulse rx_overflow; leave FIFO contents unchanged.
REQ-035 word_cnt shall increment on every successful push and wrap from FFFF to 0000.
REQ-036 RX FIFO output handshake: the word transfers when rx_tvalid and rx_tready are both high; rx_tvalid = FIFO not empty.
REQ-037 tx_tready shall equal TX FIFO not full AND enable; tx_tvalid&tx_tready pushes tx_tdata.
REQ-038 States: HUNT, ACTIVE.
REQ-039 Reset and enable=0 shall place the block in HUNT.
REQ-040 HUNT->ACTIVE on the first rise pulse sampling DSYNC=1; in HUNT no words are pushed and frame_err is never raised.
REQ-041 ACTIVE->HUNT only on enable=0 or reset.
REQ-042 In ACTIVE, the first fall pulse after a DSYNC=1 rise: pop the TX FIFO head into tx_shift and drive its MSB on DRX in the same clk.
REQ-043 Same fall pulse with the TX FIFO empty: load all zeros into tx_shift; pulse tx_underrun.
REQ-044 On every other fall pulse in ACTIVE: shift tx_shift left, zero fill, and drive the new MSB on DRX.
REQ-045 DRX shall be registered and held at 0 in HUNT.
REQ-046 Simultaneous TX pop and TX push with the FIFO not full or empty shall both take effect.
REQ-047 Simultaneous frame_err and another error event in one clk shall add 1 to err_cnt.
REQ-048 enable=0: reset bit_cnt; go to HUNT; no RX pushes; no TX pops; word_cnt and err_cnt hold; FIFO contents retained.

Reset
REQ-049 rstn=0 at a clk edge shall clear all of the following: synchronizers, bit_cnt, rx_shift, tx_shift, DRX, pulses, word_cnt, err_cnt and both FIFOs; state = HUNT.
REQ-050 rstn=0 mid-frame shall discard the partial word; the block resynchronizes on the next DSYNC.

Structure
REQ-051 Package gyro_link_pkg shall hold: the WD default, the link_state_t enum {HUNT, ACTIVE} and the ERR_SAT constant 16'hFFFF.
REQ-052 Sub-module gyro_link_edge_sync shall implement the polarity XOR, the synchronizers and the rise/fall pulses.
REQ-053 Both FIFOs shall be gen_sync_que_af instances (DPWR, WD) clocked by clk and reset by rstn.

Verification
REQ-054 Send 48 bits of 48'hA5A5_0F0F_1234 with DSYNC on the last bit, preceded by one sync frame -> rx_tdata=48'hA5A5_0F0F_1234, word_cnt=1, err_cnt=0.
REQ-055 Push tx 48'h8000_0000_0001 and run 2 frames -> DRX shows the word MSB first in frame 2 and zeros in frame 1, with 1 underrun (err_cnt=1).
REQ-056 Assert DSYNC after 30 bits in ACTIVE -> one frame_err pulse, no push, and the next 48-bit frame is received correctly.
REQ-057 Hold rx_tready=0 and send 6 frames with DPWR=2 -> 4 words stored, 2 rx_overflow pulses, word_cnt=4, err_cnt=2.
REQ-058 Use mck_pol=1 with inverted MCK, then pulse rstn low mid-frame -> data matches the REQ-054 scenario, and after reset no push occurs until the next DSYNC.
